// File: rtl/ram_dma_ci_engine.sv
// ram_dma_ci_engine: custom-instruction scratchpad SSRAM with an autonomous
// burst DMA engine that masters the shared system bus.
//
// Ports
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   start, ciN            : CI strobe and number (active when ciN == customId)
//   valueA, valueB        : CI command/address word and write data
//   done, result          : CI completion and read data (result 0 unless done)
//   requestTransaction .. : bus master outputs (request/begin/address-data,
//   endTransactionOut       read-not-write, byte enables, burst size, write
//                           beat valid, end of write transaction)
//   transactionGranted,   : bus master inputs (grant, read beats, slave end,
//   addressDataIn .. busErrorIn  write stall, bus error)
//   dmaIrq                : transfer-finished interrupt, present only when
//                           RAM_DMA_CI_IRQ_EN is defined
//
// valueA: [31:16] must be 0, [15:13] select, [12] write, [11:0] SSRAM address.
// Selects: 0 SSRAM, 1 bus addr, 2 SSRAM addr, 3 size, 4 burst,
//          5 control (wr) / status (rd), 6 words remaining.
module ram_dma_ci_engine #(
    parameter logic [7:0]  customId  = 8'h00,
    parameter int unsigned ADDR_BITS = 9
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  ciN,
    input  logic [31:0] valueA,
    input  logic [31:0] valueB,
    output logic        done,
    output logic [31:0] result,
    output logic        requestTransaction,
    input  logic        transactionGranted,
    output logic        beginTransactionOut,
    output logic [31:0] addressDataOut,
    output logic        readNotWriteOut,
    output logic [3:0]  byteEnablesOut,
    output logic [7:0]  burstSizeOut,
    output logic        dataValidOut,
    output logic        endTransactionOut,
    input  logic [31:0] addressDataIn,
    input  logic        dataValidIn,
    input  logic        endTransactionIn,
    input  logic        busyIn,
`ifdef RAM_DMA_CI_IRQ_EN
    input  logic        busErrorIn,
    output logic        dmaIrq
`else
    input  logic        busErrorIn
`endif
);

    localparam int unsigned AW    = ADDR_BITS;
    localparam int unsigned CW    = ADDR_BITS + 1;
    localparam int unsigned DEPTH = 1 << ADDR_BITS;
    localparam logic [11:0] ADDR_MASK = 12'((32'd1 << ADDR_BITS) - 32'd1);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_BEGIN, S_RDATA, S_WDATA, S_WEND, S_NEXT
    } state_e;

    logic [31:0]   mem_q [DEPTH];
    logic [31:0]   a_rdata_q, b_rdata_q;
    state_e        state_q, state_d;
    logic [31:0]   bus_addr_q, bus_addr_d, cur_bus_q, cur_bus_d;
    logic [AW-1:0] mem_start_q, mem_start_d, cur_mem_q, cur_mem_d;
    logic [CW-1:0] size_q, size_d, remaining_q, remaining_d;
    logic [7:0]    burst_q, burst_d;
    logic [15:0]   beat_cnt_q, beat_cnt_d;
    logic          error_q, error_d, dir_rd_q, dir_rd_d, rd_pend_q, rd_pend_d;

    logic          ci_active_s, ci_ok_s, wr_s, busy_s, ctrl_wr_s;
    logic [2:0]    sel_s;
    logic [11:0]   ci_addr_s;
    logic [AW-1:0] a_addr_s;
    logic          mem_a_we_s, mem_b_we_s;
    logic [15:0]   burst_beats_s, rem_ext_s, beats_s;

    assign ci_active_s = start && (ciN == customId);
    assign sel_s       = valueA[15:13];
    assign wr_s        = valueA[12];
    assign ci_addr_s   = valueA[11:0];
    assign a_addr_s    = ci_addr_s[AW-1:0];
    assign ci_ok_s     = ci_active_s && (valueA[31:16] == 16'd0) &&
                         !((sel_s == 3'd0) && ((ci_addr_s & ~ADDR_MASK) != 12'd0));
    assign busy_s      = (state_q != S_IDLE);
    assign ctrl_wr_s   = ci_ok_s && wr_s && (sel_s == 3'd5);
    assign mem_a_we_s  = ci_ok_s && wr_s && (sel_s == 3'd0);

    // Beats in the current burst: the smaller of the burst length and what is left.
    assign burst_beats_s = {8'd0, burst_q} + 16'd1;
    assign rem_ext_s     = 16'(remaining_q);
    assign beats_s       = (burst_beats_s < rem_ext_s) ? burst_beats_s : rem_ext_s;

    // CI completion and read data; SSRAM reads complete one cycle late.
    always_comb begin
        done      = 1'b0;
        result    = 32'd0;
        rd_pend_d = ci_ok_s && !wr_s && (sel_s == 3'd0);
        if (rd_pend_q) begin
            done   = 1'b1;
            result = a_rdata_q;
        end else if (ci_active_s) begin
            done = !rd_pend_d;
            if (ci_ok_s && !wr_s) begin
                case (sel_s)
                    3'd1:    result = bus_addr_q;
                    3'd2:    result = 32'(mem_start_q);
                    3'd3:    result = 32'(size_q);
                    3'd4:    result = {24'd0, burst_q};
                    3'd5:    result = {30'd0, error_q, busy_s};
                    3'd6:    result = 32'(remaining_q);
                    default: result = 32'd0;
                endcase
            end else begin
                result = 32'd0;
            end
        end else begin
            done = 1'b0;
        end
    end

    // Configuration registers; frozen while a transfer is in progress.
    always_comb begin
        bus_addr_d  = bus_addr_q;
        mem_start_d = mem_start_q;
        size_d      = size_q;
        burst_d     = burst_q;
        if (ci_ok_s && wr_s && !busy_s) begin
            case (sel_s)
                3'd1:    bus_addr_d  = {valueB[31:2], 2'b00};
                3'd2:    mem_start_d = valueB[AW-1:0];
                3'd3:    size_d      = valueB[CW-1:0];
                3'd4:    burst_d     = valueB[7:0];
                default: bus_addr_d  = bus_addr_q;
            endcase
        end else begin
            bus_addr_d = bus_addr_q;
        end
    end

    // Transfer FSM next state and bus outputs.
    always_comb begin
        state_d             = state_q;
        error_d             = error_q;
        dir_rd_d            = dir_rd_q;
        cur_bus_d           = cur_bus_q;
        cur_mem_d           = cur_mem_q;
        remaining_d         = remaining_q;
        beat_cnt_d          = beat_cnt_q;
        mem_b_we_s          = 1'b0;
        requestTransaction  = 1'b0;
        beginTransactionOut = 1'b0;
        addressDataOut      = 32'd0;
        readNotWriteOut     = 1'b0;
        byteEnablesOut      = 4'h0;
        burstSizeOut        = 8'd0;
        dataValidOut        = 1'b0;
        endTransactionOut   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ctrl_wr_s && (valueB[1:0] == 2'b01 || valueB[1:0] == 2'b10)
                    && (size_q != '0)) begin
                    state_d     = S_REQ;
                    error_d     = 1'b0;
                    dir_rd_d    = (valueB[1:0] == 2'b01);
                    cur_bus_d   = bus_addr_q;
                    cur_mem_d   = mem_start_q;
                    remaining_d = size_q;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                requestTransaction = 1'b1;
                if (transactionGranted) begin
                    state_d = S_BEGIN;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_BEGIN: begin
                requestTransaction  = 1'b1;
                beginTransactionOut = 1'b1;
                addressDataOut      = cur_bus_q;
                readNotWriteOut     = dir_rd_q;
                byteEnablesOut      = 4'hF;
                burstSizeOut        = 8'(beats_s - 16'd1);
                beat_cnt_d          = 16'd0;
                state_d             = dir_rd_q ? S_RDATA : S_WDATA;
            end
            S_RDATA: begin
                requestTransaction = 1'b1;
                if (dataValidIn) begin
                    mem_b_we_s = 1'b1;
                    cur_mem_d  = cur_mem_q + AW'(1);
                end else begin
                    cur_mem_d = cur_mem_q;
                end
                if (endTransactionIn) begin
                    state_d = S_NEXT;
                end else begin
                    state_d = S_RDATA;
                end
            end
            S_WDATA: begin
                requestTransaction = 1'b1;
                dataValidOut       = 1'b1;
                addressDataOut     = b_rdata_q;
                if (!busyIn) begin
                    cur_mem_d  = cur_mem_q + AW'(1);
                    beat_cnt_d = beat_cnt_q + 16'd1;
                    if (beat_cnt_q == beats_s - 16'd1) begin
                        state_d = S_WEND;
                    end else begin
                        state_d = S_WDATA;
                    end
                end else begin
                    state_d = S_WDATA;
                end
            end
            S_WEND: begin
                requestTransaction = 1'b1;
                endTransactionOut  = 1'b1;
                state_d            = S_NEXT;
            end
            S_NEXT: begin
                cur_bus_d   = cur_bus_q + 32'({beats_s, 2'b00});
                remaining_d = remaining_q - CW'(beats_s);
                if (remaining_q > CW'(beats_s)) begin
                    state_d = S_REQ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A bus error aborts the transfer without an end-of-transaction cycle.
        if (busy_s && busErrorIn) begin
            state_d    = S_IDLE;
            error_d    = 1'b1;
            mem_b_we_s = 1'b0;
        end else begin
            error_d = error_d;
        end
    end

    // SSRAM array: port A for the CPU, port B for the DMA. Port B reads the
    // next-cycle address so write data is ready alongside dataValidOut.
    always_ff @(posedge clock) begin
        if (mem_a_we_s) mem_q[a_addr_s] <= valueB;
        if (mem_b_we_s) mem_q[cur_mem_q] <= addressDataIn;
        a_rdata_q <= mem_q[a_addr_s];
        b_rdata_q <= mem_q[cur_mem_d];
    end

    // Control and FSM state registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            bus_addr_q  <= 32'd0;
            mem_start_q <= '0;
            size_q      <= '0;
            burst_q     <= 8'd0;
            error_q     <= 1'b0;
            dir_rd_q    <= 1'b0;
            cur_bus_q   <= 32'd0;
            cur_mem_q   <= '0;
            remaining_q <= '0;
            beat_cnt_q  <= 16'd0;
            rd_pend_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_addr_q  <= bus_addr_d;
            mem_start_q <= mem_start_d;
            size_q      <= size_d;
            burst_q     <= burst_d;
            error_q     <= error_d;
            dir_rd_q    <= dir_rd_d;
            cur_bus_q   <= cur_bus_d;
            cur_mem_q   <= cur_mem_d;
            remaining_q <= remaining_d;
            beat_cnt_q  <= beat_cnt_d;
            rd_pend_q   <= rd_pend_d;
        end
    end

`ifdef RAM_DMA_CI_IRQ_EN
    logic irq_q, irq_d;

    // Interrupt: set when a transfer returns to idle, cleared by a control write.
    always_comb begin
        irq_d = irq_q;
        if (busy_s && (state_d == S_IDLE)) begin
            irq_d = 1'b1;
        end else if (ctrl_wr_s) begin
            irq_d = 1'b0;
        end else begin
            irq_d = irq_q;
        end
    end

    // Interrupt register.
    always_ff @(posedge clock) begin
        if (reset) irq_q <= 1'b0;
        else       irq_q <= irq_d;
    end

    assign dmaIrq = irq_q;
`endif

endmodule
